gol_gen_ctrl: RTL and testbench

Generation sequencer for the 16x16 Game of Life double-buffered environment. On reset or a clear request it zeroes both environment buffers. On each step it sweeps all 256 cells in row-major order, reading the current buffer and writing the next-state value from the external rule engine into the other buffer. It counts births and deaths, then swaps the active buffer. It sits between the top-level run/step controls and the environment memory plus rule engine.

---
 rtl/gol_gen_ctrl.sv | 174 +++++++++++++++++
 tb/tb_gol_gen_ctrl.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gol_gen_ctrl.sv
// Generation sequencer for a double-buffered Game of Life grid: zeroes both
// buffers on clear, then sweeps every cell through an external rule engine.
module gol_gen_ctrl #(
    parameter int  ROWS   = 16,
    parameter int  COLS   = 16,
    parameter int  CNT_W  = 9,
    parameter int  GEN_W  = 16,
    localparam int CELLS  = ROWS * COLS,
    localparam int ADDR_W = $clog2(CELLS)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              step_i,
    input  logic              run_i,
    input  logic              clear_req_i,
    output logic [ADDR_W-1:0] rd_addr_o,
    output logic              rd_buf_o,
    input  logic              cur_cell_i,
    input  logic              nxt_cell_i,
    output logic              wr_en_o,
    output logic              wr_buf_o,
    output logic [ADDR_W-1:0] wr_addr_o,
    output logic              wr_data_o,
    output logic              busy_o,
    output logic              done_o,
    output logic [CNT_W-1:0]  birth_cnt_o,
    output logic [CNT_W-1:0]  death_cnt_o,
    output logic [GEN_W-1:0]  gen_cnt_o,
    output logic              active_buf_o
);

    // state | meaning
    // CLEAR | zero buf 0 then buf 1, one cell per cycle
    // IDLE  | wait for clear_req / step / run
    // SCAN  | read cell idx, write previous cell into the other buffer
    // DRAIN | final write for the last cell, no read
    // SWAP  | flip active buffer, publish tallies, pulse done
    typedef enum logic [2:0] {S_CLEAR, S_IDLE, S_SCAN, S_DRAIN, S_SWAP} state_e;

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(CELLS - 1);

    state_e             state_q, state_d;
    logic [ADDR_W-1:0]  idx_q, idx_d;
    logic               pass_q, pass_d;
    logic               wr_pend_q, wr_pend_d;
    logic [ADDR_W-1:0]  wr_addr_q, wr_addr_d;
    logic [CNT_W-1:0]   birth_tally_q, birth_tally_d;
    logic [CNT_W-1:0]   death_tally_q, death_tally_d;
    logic [CNT_W-1:0]   birth_cnt_q, birth_cnt_d;
    logic [CNT_W-1:0]   death_cnt_q, death_cnt_d;
    logic [GEN_W-1:0]   gen_cnt_q, gen_cnt_d;
    logic               active_q, active_d;
    logic               clear_last;

    assign clear_last = (state_q == S_CLEAR) && pass_q && (idx_q == LAST);

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= S_CLEAR;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_CLEAR: if (clear_last) state_d = S_IDLE;
            S_IDLE: begin
                if (clear_req_i)         state_d = S_CLEAR;
                else if (step_i || run_i) state_d = S_SCAN;
            end
            S_SCAN: begin
                if (clear_req_i)        state_d = S_CLEAR;
                else if (idx_q == LAST) state_d = S_DRAIN;
            end
            S_DRAIN: state_d = clear_req_i ? S_CLEAR : S_SWAP;
            S_SWAP:  state_d = (run_i && !clear_req_i) ? S_SCAN : S_IDLE;
            default: state_d = S_CLEAR;
        endcase
    end

    always_comb begin
        idx_d         = '0;
        pass_d        = pass_q;
        wr_pend_d     = (state_q == S_SCAN) && (state_d != S_CLEAR);
        wr_addr_d     = idx_q;
        birth_tally_d = birth_tally_q;
        death_tally_d = death_tally_q;
        birth_cnt_d   = birth_cnt_q;
        death_cnt_d   = death_cnt_q;
        gen_cnt_d     = gen_cnt_q;
        active_d      = active_q;

        if (state_q == S_CLEAR || state_q == S_SCAN) idx_d = idx_q + ADDR_W'(1);
        if (state_q == S_CLEAR && idx_q == LAST) pass_d = ~pass_q;

        if (state_q == S_IDLE || state_q == S_SWAP) begin
            birth_tally_d = '0;
            death_tally_d = '0;
        end else if (wr_pend_q) begin
            if (!cur_cell_i && nxt_cell_i) birth_tally_d = birth_tally_q + CNT_W'(1);
            if (cur_cell_i && !nxt_cell_i) death_tally_d = death_tally_q + CNT_W'(1);
        end

        if (state_q == S_SWAP) begin
            birth_cnt_d = birth_tally_q;
            death_cnt_d = death_tally_q;
            gen_cnt_d   = gen_cnt_q + GEN_W'(1);
            active_d    = ~active_q;
        end

        // An aborted sweep keeps its published results until the clear finishes.
        if (clear_last) begin
            birth_cnt_d   = '0;
            death_cnt_d   = '0;
            gen_cnt_d     = '0;
            active_d      = 1'b0;
            birth_tally_d = '0;
            death_tally_d = '0;
        end

        if (state_d == S_CLEAR && state_q != S_CLEAR) begin
            idx_d  = '0;
            pass_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            idx_q         <= '0;
            pass_q        <= 1'b0;
            wr_pend_q     <= 1'b0;
            wr_addr_q     <= '0;
            birth_tally_q <= '0;
            death_tally_q <= '0;
            birth_cnt_q   <= '0;
            death_cnt_q   <= '0;
            gen_cnt_q     <= '0;
            active_q      <= 1'b0;
        end else begin
            idx_q         <= idx_d;
            pass_q        <= pass_d;
            wr_pend_q     <= wr_pend_d;
            wr_addr_q     <= wr_addr_d;
            birth_tally_q <= birth_tally_d;
            death_tally_q <= death_tally_d;
            birth_cnt_q   <= birth_cnt_d;
            death_cnt_q   <= death_cnt_d;
            gen_cnt_q     <= gen_cnt_d;
            active_q      <= active_d;
        end
    end

    always_comb begin
        rd_addr_o    = (state_q == S_SCAN) ? idx_q : '0;
        rd_buf_o     = active_q;
        busy_o       = (state_q != S_IDLE);
        done_o       = !rst_i && ((state_q == S_SWAP) || clear_last);
        birth_cnt_o  = birth_cnt_q;
        death_cnt_o  = death_cnt_q;
        gen_cnt_o    = gen_cnt_q;
        active_buf_o = active_q;
        if (state_q == S_CLEAR) begin
            wr_en_o   = !rst_i;
            wr_buf_o  = pass_q;
            wr_addr_o = idx_q;
            wr_data_o = 1'b0;
        end else begin
            wr_en_o   = !rst_i && wr_pend_q;
            wr_buf_o  = ~active_q;
            wr_addr_o = wr_addr_q;
            wr_data_o = wr_pend_q && nxt_cell_i;
        end
    end

endmodule

// File: tb/tb_gol_gen_ctrl.sv
// Scoreboard bench: environment memory + rule engine model, a reference grid
// model producing expected writes/done records, and a decoupled monitor.
module tb_gol_gen_ctrl;

    localparam int CELLS = 256;
    localparam int NCOL  = 16;
    localparam int NROW  = 16;

    logic        clk, rst, step, run, clear_req;
    logic [7:0]  rd_addr, wr_addr;
    logic        rd_buf, cur_cell, nxt_cell, wr_en, wr_buf, wr_data;
    logic        busy, done, active_buf;
    logic [8:0]  birth_cnt, death_cnt;
    logic [15:0] gen_cnt;

    gol_gen_ctrl dut (
        .clk_i(clk), .rst_i(rst), .step_i(step), .run_i(run), .clear_req_i(clear_req),
        .rd_addr_o(rd_addr), .rd_buf_o(rd_buf), .cur_cell_i(cur_cell), .nxt_cell_i(nxt_cell),
        .wr_en_o(wr_en), .wr_buf_o(wr_buf), .wr_addr_o(wr_addr), .wr_data_o(wr_data),
        .busy_o(busy), .done_o(done), .birth_cnt_o(birth_cnt), .death_cnt_o(death_cnt),
        .gen_cnt_o(gen_cnt), .active_buf_o(active_buf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic life_cell(input logic [255:0] g, input int idx);
        int r, c, n;
        r = idx / NCOL;
        c = idx % NCOL;
        n = 0;
        for (int dr = -1; dr <= 1; dr++)
            for (int dc = -1; dc <= 1; dc++)
                if ((dr != 0 || dc != 0) && r + dr >= 0 && r + dr < NROW &&
                    c + dc >= 0 && c + dc < NCOL)
                    n += int'(g[(r + dr) * NCOL + c + dc]);
        return g[idx] ? (n == 2 || n == 3) : (n == 3);
    endfunction

    // environment: two grid buffers plus the rule engine, one-cycle read latency
    logic [255:0] mem [2];
    logic [255:0] load_pat;
    logic         load_req, load_bsel;

    always @(posedge clk) begin
        if (load_req) mem[load_bsel] <= load_pat;
        else if (wr_en) mem[wr_buf][wr_addr] <= wr_data;
    end

    always @(posedge clk) begin
        cur_cell <= mem[rd_buf][rd_addr];
        nxt_cell <= life_cell(mem[rd_buf], int'(rd_addr));
    end

    typedef struct packed {
        logic       bsel;
        logic [7:0] addr;
        logic       data;
    } wr_rec_t;

    typedef struct {
        int   cyc;
        int   birth;
        int   death;
        int   gen;
        logic active;
        logic busy_after;
    } done_rec_t;

    wr_rec_t   wq[$];
    done_rec_t dq[$];

    logic [255:0] ref_grid;
    logic         ref_active;
    int           ref_gen;

    int checks = 0;
    int errors = 0;
    bit cnt_pend = 0;
    bit drv_timeout = 0;
    bit end_req = 0;
    bit end_ack = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // monitor: pops expected writes / done records whenever the DUT presents one
    initial begin : monitor
        done_rec_t cur_rec;
        wr_rec_t   w, got;
        bit        rst_seen, to_rep;
        rst_seen = 0;
        to_rep   = 0;
        cur_rec  = '{0, 0, 0, 0, 1'b0, 1'b0};
        forever begin
            @(negedge clk);
            if (rst) begin
                chk("rst_wr_en", int'(wr_en), 0);
                chk("rst_done", int'(done), 0);
                rst_seen = 1;
            end else begin
                if (rst_seen) begin
                    rst_seen = 0;
                    chk("post_rst_gen", int'(gen_cnt), 0);
                    chk("post_rst_birth", int'(birth_cnt), 0);
                    chk("post_rst_death", int'(death_cnt), 0);
                    chk("post_rst_active", int'(active_buf), 0);
                    chk("post_rst_busy", int'(busy), 1);
                end
                if (cnt_pend) begin
                    cnt_pend = 0;
                    chk("birth_cnt", int'(birth_cnt), cur_rec.birth);
                    chk("death_cnt", int'(death_cnt), cur_rec.death);
                    chk("gen_cnt", int'(gen_cnt), cur_rec.gen);
                    chk("active_buf", int'(active_buf), int'(cur_rec.active));
                    chk("busy_after_done", int'(busy), int'(cur_rec.busy_after));
                end
                if (wr_en) begin
                    got = '{bsel: wr_buf, addr: wr_addr, data: wr_data};
                    if (wq.size() == 0) begin
                        chk("unexpected_write", int'(got), -1);
                    end else begin
                        w = wq.pop_front();
                        chk("write{buf,addr,data}", int'(got), int'(w));
                    end
                end
                if (done) begin
                    if (dq.size() == 0) begin
                        chk("unexpected_done", cyc, -1);
                    end else begin
                        cur_rec = dq.pop_front();
                        chk("done_cycle", cyc, cur_rec.cyc);
                        cnt_pend = 1;
                    end
                end
            end
            if (drv_timeout && !to_rep) begin
                to_rep = 1;
                chk("wait_timeout", 1, 0);
            end
            if (end_req && !end_ack) begin
                chk("writes_left", wq.size(), 0);
                chk("dones_left", dq.size(), 0);
                end_ack = 1;
            end
        end
    end

    task automatic push_gen(input int n_writes, input int done_cyc, input logic busy_after);
        logic [255:0] nxt;
        int b, d;
        b = 0;
        d = 0;
        for (int i = 0; i < CELLS; i++) begin
            nxt[i] = life_cell(ref_grid, i);
            if (!ref_grid[i] && nxt[i]) b++;
            if (ref_grid[i] && !nxt[i]) d++;
        end
        for (int i = 0; i < n_writes; i++)
            wq.push_back('{bsel: ~ref_active, addr: 8'(i), data: nxt[i]});
        if (n_writes == CELLS) begin
            dq.push_back('{done_cyc, b, d, (ref_gen + 1) % 65536, ~ref_active, busy_after});
            ref_grid   = nxt;
            ref_active = ~ref_active;
            ref_gen    = (ref_gen + 1) % 65536;
        end
    endtask

    task automatic push_clear(input int done_cyc);
        for (int p = 0; p < 2; p++)
            for (int i = 0; i < CELLS; i++)
                wq.push_back('{bsel: p[0], addr: 8'(i), data: 1'b0});
        dq.push_back('{done_cyc, 0, 0, 0, 1'b0, 1'b0});
        ref_grid   = '0;
        ref_active = 1'b0;
        ref_gen    = 0;
    endtask

    task automatic load_grid(input logic [255:0] g);
        load_pat  = g;
        load_bsel = ref_active;
        load_req  = 1'b1;
        @(posedge clk);
        #1;
        load_req  = 1'b0;
        ref_grid  = g;
    endtask

    task automatic do_step();
        push_gen(CELLS, cyc + 258, 1'b0);
        step = 1'b1;
        @(posedge clk);
        #1;
        step = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while ((dq.size() != 0 || cnt_pend) && n < budget) begin
            @(posedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        if (dq.size() != 0 || cnt_pend) drv_timeout = 1;
    endtask

    function automatic logic [255:0] rand_grid();
        logic [255:0] g;
        for (int i = 0; i < 8; i++) g[i*32 +: 32] = $urandom();
        return g;
    endfunction

    initial begin : driver
        logic [255:0] blinker, full;
        int s, n;
        rst = 1'b1; step = 1'b0; run = 1'b0; clear_req = 1'b0;
        load_req = 1'b0; load_bsel = 1'b0; load_pat = '0;
        ref_grid = '0; ref_active = 1'b0; ref_gen = 0;
        blinker = '0;
        blinker[8'h17] = 1'b1;
        blinker[8'h18] = 1'b1;
        blinker[8'h19] = 1'b1;
        full = '1;

        repeat (3) @(posedge clk);
        #1;
        push_clear(cyc + 511);
        rst = 1'b0;
        wait_idle(700);

        load_grid(blinker);
        do_step();
        wait_idle(400);

        push_clear(cyc + 512);
        clear_req = 1'b1;
        @(posedge clk);
        #1;
        clear_req = 1'b0;
        wait_idle(700);

        load_grid(blinker);
        s = cyc;
        for (int k = 1; k <= 3; k++) push_gen(CELLS, s + 258 * k, k < 3);
        run = 1'b1;
        repeat (2 * 258 + 10) @(posedge clk);
        #1;
        run = 1'b0;
        wait_idle(1000);

        load_grid(full);
        do_step();
        wait_idle(400);

        for (int k = 0; k < 3; k++) begin
            load_grid(rand_grid());
            do_step();
            wait_idle(400);
        end

        load_grid(rand_grid());
        push_gen(100, 0, 1'b0);
        step = 1'b1;
        @(posedge clk);
        #1;
        step = 1'b0;
        repeat (100) @(posedge clk);
        #1;
        push_clear(cyc + 512);
        clear_req = 1'b1;
        @(posedge clk);
        #1;
        clear_req = 1'b0;
        wait_idle(800);

        load_grid(rand_grid());
        push_gen(49, 0, 1'b0);
        step = 1'b1;
        @(posedge clk);
        #1;
        step = 1'b0;
        repeat (50) @(posedge clk);
        #1;
        push_clear(cyc + 512);
        rst = 1'b1;
        step = 1'b1;
        clear_req = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        step = 1'b0;
        clear_req = 1'b0;
        wait_idle(800);

        end_req = 1;
        n = 0;
        while (!end_ack && n < 10) begin
            @(posedge clk);
            n++;
        end
        if (!end_ack) begin
            $display("FAIL monitor_end: got 0 expected 1");
            $fatal(1, "monitor did not acknowledge end");
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
